data_mem_lsu: RTL and testbench

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

---
 rtl/data_mem_lsu.sv | 153 +++++++++++++++
 tb/tb_data_mem_lsu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// Purpose : RV32I data memory with load/store unit. Handles byte, half and word
//           stores with per-lane enables, and sign- or zero-extended loads.
// Latency : 1 cycle. resp_valid/rdata/err are registered one cycle after acceptance.
// Backpressure: none. One request is accepted on every clock where req_valid=1 and rst_n=1.
// Ports   : clk, rst_n (synchronous, active-low)
//           req_valid/req_we/funct3/addr/wdata  -> request
//           resp_valid/rdata/err                <- response
// Config  : define DATA_MEM_LSU_MISALIGN_TRAP_EN to flag misaligned half/word
//           accesses with err=1 and no write. When it is undefined, those
//           accesses are forced to natural alignment and complete normally.
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic          accept;
    logic          is_half;
    logic          is_word;
    logic          legal;
    logic          misalign;
    logic          fault;
    logic          wr_en;
    logic [3:0]    wr_be;
    logic [31:0]   wr_dat;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_ext;

    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    // Addresses wrap modulo the array size, so the upper bits never take part.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign word_idx = addr[AW+1:2];
    assign accept   = req_valid && rst_n;
    assign is_half  = (funct3[1:0] == 2'b01);
    assign is_word  = (funct3[1:0] == 2'b10);

    always_comb begin
        legal = 1'b0;
        if (req_we) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end
    end

`ifdef DATA_MEM_LSU_MISALIGN_TRAP_EN
    assign misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    // Misaligned accesses are silently aligned: half uses addr[1] only and
    // word ignores addr[1:0] in the lane selection below.
    assign misalign = 1'b0;
`endif

    assign fault = !legal || misalign;
    assign wr_en = accept && req_we && !fault;

    // Store lanes: data is replicated across lanes so only the byte enables
    // decide which bytes are written.
    always_comb begin
        wr_be  = 4'b0000;
        wr_dat = wdata;
        case (funct3[1:0])
            2'b00: begin
                wr_be  = 4'b0001 << addr[1:0];
                wr_dat = {4{wdata[7:0]}};
            end
            2'b01: begin
                wr_be  = addr[1] ? 4'b1100 : 4'b0011;
                wr_dat = {2{wdata[15:0]}};
            end
            2'b10: begin
                wr_be  = 4'b1111;
                wr_dat = wdata;
            end
            default: begin
                wr_be  = 4'b0000;
                wr_dat = wdata;
            end
        endcase
    end

    // No reset on the array: contents survive reset and start undefined.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                mem_q[word_idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

    // The read uses the pre-edge array contents. A store accepted one cycle
    // earlier has already been committed, so a following load sees it.
    assign rd_word = mem_q[word_idx];
    assign rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_ext = 32'h0;
        case (funct3)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_ext = rd_word;
            3'b100:  ld_ext = {24'h0, rd_byte};
            3'b101:  ld_ext = {16'h0, rd_half};
            default: ld_ext = 32'h0;
        endcase
    end

    always_comb begin
        resp_valid_d = accept;
        err_d        = accept && fault;
        rdata_d      = (accept && !req_we && !fault) ? ld_ext : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Purpose : self-checking bench for data_mem_lsu using a cycle-tagged scoreboard.
// Latency : every driven cycle pushes the response expected one edge later.
// Backpressure: none; one stimulus cycle is driven per clock.
module tb_data_mem_lsu;

    localparam int DEPTH = 256;
`ifdef DATA_MEM_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    // Word at 0x10 after the misaligned SW 0x12 test.
    localparam logic [31:0] CUR = TRAP ? 32'hDEAD55EF : 32'h12345678;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        err;

    always #5 clk = ~clk;

    data_mem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .resp_valid (resp_valid),
        .err        (err)
    );

    typedef struct {
        int          due;
        logic        vld;
        logic [31:0] dat;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Drives one cycle of stimulus and queues the response due after the next edge.
    task automatic drive(input string tag, input logic rst, input logic v, input logic we,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic ev, input logic [31:0] ed, input logic ee);
        exp_t x;
        @(posedge clk);
        #2;
        rst_n     = rst;
        req_valid = v;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        x.due = cyc + 1;
        x.vld = ev;
        x.dat = ed;
        x.err = ee;
        x.tag = tag;
        sb.push_back(x);
        started = 1'b1;
    endtask

    task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] ed, input logic ee);
        drive(tag, 1'b1, 1'b1, 1'b0, f3, a, 32'h0, 1'b1, ed, ee);
    endtask

    task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic ee);
        drive(tag, 1'b1, 1'b1, 1'b1, f3, a, wd, 1'b1, 32'h0, ee);
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b1, 1'b0, 1'b0, F_W, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check({e.tag, ".vld"}, {31'h0, resp_valid}, {31'h0, e.vld});
            check({e.tag, ".dat"}, rdata, e.dat);
            check({e.tag, ".err"}, {31'h0, err}, {31'h0, e.err});
        end else if (started) begin
            check("unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        drive("reset", 1'b0, 1'b0, 1'b0, F_W, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive("reset2", 1'b0, 1'b0, 1'b0, F_W, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        st("sw_10", F_W, 32'h10, 32'hDEADBEEF, 1'b0);
        ld("lw_10", F_W, 32'h10, 32'hDEADBEEF, 1'b0);
        ld("lb_13", F_B, 32'h13, 32'hFFFFFFDE, 1'b0);
        ld("lbu_13", F_BU, 32'h13, 32'h000000DE, 1'b0);
        ld("lh_10", F_H, 32'h10, 32'hFFFFBEEF, 1'b0);
        ld("lhu_12", F_HU, 32'h12, 32'h0000DEAD, 1'b0);
        st("sb_11", F_B, 32'h11, 32'hAAAAAA55, 1'b0);
        ld("lw_after_sb", F_W, 32'h10, 32'hDEAD55EF, 1'b0);
        idle("idle1");

        ld("lw_mis_12", F_W, 32'h12, TRAP ? 32'h0 : 32'hDEAD55EF, TRAP);
        st("sw_mis_12", F_W, 32'h12, 32'h12345678, TRAP);
        ld("lw_after_mis", F_W, 32'h10, CUR, 1'b0);
        ld("lh_mis_11", F_H, 32'h11, TRAP ? 32'h0 : 32'h00005678, TRAP);

        ld("ld_ill_011", 3'b011, 32'h10, 32'h0, 1'b1);
        ld("ld_ill_111", 3'b111, 32'h10, 32'h0, 1'b1);
        st("st_ill_011", 3'b011, 32'h10, 32'hFFFFFFFF, 1'b1);
        st("st_ill_100", 3'b100, 32'h10, 32'hFFFFFFFF, 1'b1);
        ld("lw_after_ill", F_W, 32'h10, CUR, 1'b0);
        ld("lw_wrap", F_W, DEPTH * 4 + 32'h10, CUR, 1'b0);

        st("sw_20", F_W, 32'h20, 32'h0, 1'b0);
        st("sb_wrap_20", F_B, DEPTH * 4 + 32'h20, 32'hFFFFFF7F, 1'b0);
        st("sh_22", F_H, 32'h22, 32'hABCD8001, 1'b0);
        ld("lw_20", F_W, 32'h20, 32'h8001007F, 1'b0);
        ld("lh_22", F_H, 32'h22, 32'hFFFF8001, 1'b0);
        ld("lhu_22", F_HU, 32'h22, 32'h00008001, 1'b0);
        ld("lb_20", F_B, 32'h20, 32'h0000007F, 1'b0);
        ld("lb_23", F_B, 32'h23, 32'hFFFFFF80, 1'b0);
        ld("lbu_22", F_BU, 32'h22, 32'h00000001, 1'b0);

        ld("lw_pre_rst", F_W, 32'h10, CUR, 1'b0);
        drive("sw_in_rst", 1'b0, 1'b1, 1'b1, F_W, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        ld("lw_post_rst", F_W, 32'h10, CUR, 1'b0);
        idle("idle2");
        idle("idle3");

        repeat (3) @(posedge clk);
        check("drain", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
